alu_seq_engine: RTL
===================

// Module: alu_seq_engine
// PURPOSE
//  Handshaked, multi-cycle ALU responder: accepts one {opcode, a, b, n_bit} command per transaction
//  and returns a 2*WIDTH-bit result. Sits between the command initiator (sequencer or bench) and the
//  result consumer. Logic ops complete in one cycle. MUL, DIV and shifts/rotates iterate one step per cycle.
// PARAMETERS
//  WIDTH   8  operand width; result is 2*WIDTH bits
//  NW      4  width of n_bit, the shift/rotate amount
// PORTS
//  clk        in   1        single clock; all logic on posedge
//  rst_n      in   1        synchronous, active-low reset
//  in_valid   in   1        command valid
//  in_ready   out  1        engine can accept a command
//  opcode     in   4        operation select (see BEHAVIOUR)
//  a, b       in   WIDTH    operands, unsigned unless stated
//  n_bit      in   NW       shift/rotate amount
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts the result
//  result     out  2*WIDTH  result
//  err        out  1        qualifies result; set on DIV by zero
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, result=0, err=0, all internal registers cleared.
//   Reset mid-operation aborts the command. No result is produced for it.
//  FSM IDLE->EXEC->DONE->IDLE:
//   - Command accepted when in_valid&&in_ready.
//   - in_ready=1 only in IDLE.
//   - Operands and opcode are captured on accept. Later input changes are ignored.
//   - EXEC runs the step counter. Single-cycle ops spend exactly 1 cycle in EXEC.
//   - DONE drives out_valid=1. result and err are held stable until out_ready=1.
//   - Returns to IDLE the cycle after out_valid&&out_ready.
//  Latency from accept edge to out_valid: logic/add=2 cycles; MUL/DIV=WIDTH+1; shifts=max(n_bit,1)+1.
//  No back-to-back overlap. The next accept happens no earlier than the cycle after the DONE handshake.
//  Opcodes (results zero-extended to 2*WIDTH unless stated):
//   0  ADD   a+b, including carry
//   1  SUB   a-b, two's complement, sign-extended to 2*WIDTH
//   2  MUL   a*b, shift-add, WIDTH steps
//   3  DIV   restoring division, WIDTH steps; {remainder, quotient} = result[15:8], result[7:0]
//            b==0: result=16'hFFFF, err=1, still WIDTH steps
//   4  AND   5 OR   6 XOR   7 NOT a   8 NAND   9 NOR   10 XNOR   (operate on WIDTH bits)
//   11 SHL   a<<n_bit, on 2*WIDTH bits
//   12 SHR   logical a>>n_bit
//   13 ROL   a, within WIDTH bits
//   14 ROR   a, within WIDTH bits
//        (11-14: one bit per step; n_bit=0 returns a unchanged after 1 step)
//   15 CMP   result[2:0]={a>b, a==b, a<b}, upper bits 0
//  err=0 for every opcode except DIV by zero.
//  Simultaneous out_ready=1 and in_valid=1 while in DONE: the command is not accepted that cycle
//   (in_ready=0 because state is not IDLE).
//  out_ready held high before DONE has no effect.
// STRUCTURE
//  alu_pkg (shared package):
//   - opcode_e enum (the 16 codes above)
//   - state_e {IDLE, EXEC, DONE}
//   - localparam RES_W = 2*WIDTH
//   - helpers is_iter(op), iter_count(op, n)
//  Sub-module alu_iter_unit: iterative MUL/DIV/shift datapath with start/done. The FSM and
//   single-cycle ops live in the top.
// TESTING
//  1. Reset held 3 cycles during MUL EXEC -> out_valid=0, in_ready=1, result=0 after release.
//  2. ADD a=8'h0C b=8'h03 -> result=16'd15 exactly 2 cycles after accept, err=0.
//  3. MUL a=8'hF6 b=8'h0A -> result=16'h099C after 9 cycles.
//     DIV a=8'hF6 b=8'h0A -> result=16'h0618 (remainder 6, quotient 24).
//     DIV b=0 -> 16'hFFFF, err=1.
//  4. SHL a=8'h0C n_bit=2 -> 16'h0030 in 3 cycles.
//     ROR a=8'h81 n_bit=1 -> 16'h00C0.
//     SHR n_bit=0 -> a after 2 cycles.
//  5. Backpressure: out_ready=0 for 5 cycles in DONE -> result/err stable, in_ready=0, inputs ignored.
//     Accept happens on the cycle after out_ready=1.
//  6. Sweep opcode 1..15 with a=8'h0C b=8'h03 n_bit=2, random out_ready -> each result matches the
//     reference model, one result per command, none dropped or duplicated.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// alu_pkg : opcode/state types and step-count helpers for alu_seq_engine
// Rev 1.0
//==============================================================================
package alu_pkg;

   localparam int ALU_WIDTH = 8;
   localparam int ALU_NW    = 4;
   localparam int RES_W     = 2 * ALU_WIDTH;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_MUL  = 4'd2,
      OP_DIV  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_NOT  = 4'd7,
      OP_NAND = 4'd8,
      OP_NOR  = 4'd9,
      OP_XNOR = 4'd10,
      OP_SHL  = 4'd11,
      OP_SHR  = 4'd12,
      OP_ROL  = 4'd13,
      OP_ROR  = 4'd14,
      OP_CMP  = 4'd15
   } opcode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic is_iter(input opcode_e op);
      return op inside {OP_MUL, OP_DIV, OP_SHL, OP_SHR, OP_ROL, OP_ROR};
   endfunction

   // Cycles spent in EXEC; a zero shift amount still burns one step.
   function automatic int iter_count(input opcode_e op, input int n, input int w);
      if (op == OP_MUL || op == OP_DIV) return w;
      if (is_iter(op)) return (n == 0) ? 1 : n;
      return 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_unit.sv
`default_nettype none
//==============================================================================
// alu_iter_unit : one-step-per-cycle datapath for MUL, DIV, shifts and rotates
// Rev 1.0
//==============================================================================
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int NW    = ALU_NW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  opcode_e              i_op,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   input  logic [NW-1:0]        i_n,
   output logic                 o_done,
   output logic [2*WIDTH-1:0]   o_res_next
);

   localparam int c_max_steps = (WIDTH > (2**NW) - 1) ? WIDTH : (2**NW) - 1;
   localparam int c_cw        = $clog2(c_max_steps + 1);

   logic                 r_busy;
   opcode_e              r_op;
   logic [c_cw-1:0]      r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_x;
   logic [WIDTH-1:0]     r_y;
   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_b;
   logic                 r_shift_en;

   logic [2*WIDTH-1:0]   w_acc_n;
   logic [2*WIDTH-1:0]   w_x_n;
   logic [WIDTH:0]       w_div_sh;
   logic                 w_div_ge;
   logic [WIDTH-1:0]     w_div_sub;
   logic [WIDTH-1:0]     w_rem_n;
   logic [WIDTH-1:0]     w_quo_n;

   assign w_acc_n = r_y[0] ? (r_acc + r_x) : r_acc;

   // Restoring division: r_y starts as the dividend and fills with quotient bits.
   assign w_div_sh  = {r_rem, r_y[WIDTH-1]};
   assign w_div_ge  = (w_div_sh >= {1'b0, r_b});
   assign w_div_sub = w_div_sh[WIDTH-1:0] - r_b;
   assign w_rem_n   = w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
   assign w_quo_n   = {r_y[WIDTH-2:0], w_div_ge};

   always_comb begin
      w_x_n = r_x;
      if (r_shift_en) begin
         case (r_op)
            OP_SHL:  w_x_n = r_x << 1;
            OP_SHR:  w_x_n = r_x >> 1;
            OP_ROL:  w_x_n = {{WIDTH{1'b0}}, r_x[WIDTH-2:0], r_x[WIDTH-1]};
            OP_ROR:  w_x_n = {{WIDTH{1'b0}}, r_x[0], r_x[WIDTH-1:1]};
            default: w_x_n = r_x;
         endcase
      end
   end

   always_comb begin
      case (r_op)
         OP_MUL:  o_res_next = w_acc_n;
         OP_DIV:  o_res_next = {w_rem_n, w_quo_n};
         default: o_res_next = w_x_n;
      endcase
   end

   assign o_done = r_busy && (r_cnt == c_cw'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy     <= 1'b0;
         r_op       <= OP_ADD;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_rem      <= '0;
         r_b        <= '0;
         r_shift_en <= 1'b0;
      end else if (i_start) begin
         r_busy     <= 1'b1;
         r_op       <= i_op;
         r_cnt      <= c_cw'(iter_count(i_op, int'(i_n), WIDTH));
         r_acc      <= '0;
         r_x        <= {{WIDTH{1'b0}}, i_a};
         r_y        <= (i_op == OP_DIV) ? i_a : i_b;
         r_rem      <= '0;
         r_b        <= i_b;
         r_shift_en <= (i_n != '0);
      end else if (r_busy) begin
         r_cnt <= r_cnt - c_cw'(1);
         if (r_cnt == c_cw'(1)) r_busy <= 1'b0;
         case (r_op)
            OP_MUL: begin
               r_acc <= w_acc_n;
               r_x   <= r_x << 1;
               r_y   <= r_y >> 1;
            end
            OP_DIV: begin
               r_rem <= w_rem_n;
               r_y   <= w_quo_n;
            end
            default: r_x <= w_x_n;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_seq_engine.sv
`default_nettype none
//==============================================================================
// alu_seq_engine : handshaked multi-cycle ALU responder (IDLE -> EXEC -> DONE)
// Rev 1.0
//==============================================================================
module alu_seq_engine
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int NW    = ALU_NW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           opcode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [NW-1:0]        n_bit,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 err
);

   localparam int c_res_w = 2 * WIDTH;

   state_e               r_state;
   state_e               w_state_n;
   opcode_e              r_op;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [c_res_w-1:0]   r_result;
   logic                 r_err;

   logic                 w_accept;
   logic                 w_load;
   logic                 w_iter_start;
   logic                 w_iter_done;
   logic                 w_div_zero;
   logic [c_res_w-1:0]   w_iter_res;
   logic [c_res_w-1:0]   w_single_res;
   logic [WIDTH-1:0]     w_logic;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_diff;

   assign w_iter_start = w_accept && is_iter(opcode_e'(opcode));
   assign w_div_zero   = (r_op == OP_DIV) && (r_b == '0);
   assign w_sum        = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff       = {1'b0, r_a} - {1'b0, r_b};

   alu_iter_unit #(
      .WIDTH (WIDTH),
      .NW    (NW)
   ) u_iter (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_iter_start),
      .i_op       (opcode_e'(opcode)),
      .i_a        (a),
      .i_b        (b),
      .i_n        (n_bit),
      .o_done     (w_iter_done),
      .o_res_next (w_iter_res)
   );

   always_comb begin
      case (r_op)
         OP_AND:  w_logic = r_a & r_b;
         OP_OR:   w_logic = r_a | r_b;
         OP_XOR:  w_logic = r_a ^ r_b;
         OP_NOT:  w_logic = ~r_a;
         OP_NAND: w_logic = ~(r_a & r_b);
         OP_NOR:  w_logic = ~(r_a | r_b);
         OP_XNOR: w_logic = ~(r_a ^ r_b);
         default: w_logic = '0;
      endcase
   end

   // The (WIDTH+1)-bit difference is already two's complement; widen by its sign bit.
   always_comb begin
      case (r_op)
         OP_ADD:  w_single_res = {{(WIDTH-1){1'b0}}, w_sum};
         OP_SUB:  w_single_res = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
         OP_CMP:  w_single_res = {{(c_res_w-3){1'b0}}, (r_a > r_b), (r_a == r_b), (r_a < r_b)};
         default: w_single_res = {{WIDTH{1'b0}}, w_logic};
      endcase
   end

   always_comb begin
      w_state_n = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      w_accept  = 1'b0;
      w_load    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept  = 1'b1;
               w_state_n = EXEC;
            end
         end
         EXEC: begin
            if (!is_iter(r_op) || w_iter_done) begin
               w_load    = 1'b1;
               w_state_n = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_n = IDLE;
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_op     <= OP_ADD;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_n;
         if (w_accept) begin
            r_op <= opcode_e'(opcode);
            r_a  <= a;
            r_b  <= b;
         end
         if (w_load) begin
            if (w_div_zero) begin
               r_result <= '1;
               r_err    <= 1'b1;
            end else begin
               r_result <= is_iter(r_op) ? w_iter_res : w_single_res;
               r_err    <= 1'b0;
            end
         end
      end
   end

   assign result = r_result;
   assign err    = r_err;

endmodule
`default_nettype wire
